word_slot_collector: RTL and testbench

WORD_SLOT_COLLECTOR -- requirements
Module: word_slot_collector

---
 rtl/word_slot_collector_if.sv | 40 ++++
 rtl/word_slot_collector.sv | 108 ++++++++++
 tb/tb_word_slot_collector.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/word_slot_collector_if.sv
// ---------------------------------------------------------------------------
// word_slot_collector_if
// Purpose : Bundles the word-in handshake, the flush request and the
//           bundle-out handshake of word_slot_collector into one interface.
// Signals :
//   in_word   [WORD_WIDTH]            incoming word (producer -> collector)
//   in_valid                          in_word valid this cycle
//   in_ready                          collector can accept in_word
//   flush                             request early release of a partial bundle
//   out_words [WORD_WIDTH*WORD_COUNT] bundle, slot k at [k*WORD_WIDTH +: WORD_WIDTH]
//   out_valid                         bundle complete and stable
//   out_ready                         consumer takes the bundle
//   out_count [COUNT_WIDTH]           number of written slots
// Modports: master = producer/consumer side, slave = collector side.
// ---------------------------------------------------------------------------
interface word_slot_collector_if #(
    parameter int WORD_WIDTH = 36,
    parameter int WORD_COUNT = 16
);
    localparam int COUNT_WIDTH = $clog2(WORD_COUNT + 1);

    logic [WORD_WIDTH-1:0]            in_word;
    logic                             in_valid;
    logic                             in_ready;
    logic                             flush;
    logic [WORD_WIDTH*WORD_COUNT-1:0] out_words;
    logic                             out_valid;
    logic                             out_ready;
    logic [COUNT_WIDTH-1:0]           out_count;

    modport master (
        output in_word, in_valid, flush, out_ready,
        input  in_ready, out_words, out_valid, out_count
    );

    modport slave (
        input  in_word, in_valid, flush, out_ready,
        output in_ready, out_words, out_valid, out_count
    );
endinterface

// File: rtl/word_slot_collector.sv
// ---------------------------------------------------------------------------
// word_slot_collector
// Purpose : Collects up to WORD_COUNT words into a flat bundle. Words fill
//           slots 0,1,2,... in arrival order; the bundle is released either
//           when all slots are written or early on flush. While the bundle is
//           presented (HOLD) it is frozen until the consumer takes it, after
//           which every slot returns to zero (the neutral value for a
//           downstream OR reduction).
// Ports   :
//   clock  in   single clock, rising edge
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of word_slot_collector_if (see interface header)
// ---------------------------------------------------------------------------
module word_slot_collector #(
    parameter int WORD_WIDTH = 36,
    parameter int WORD_COUNT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    word_slot_collector_if.slave    bus
);
    localparam int COUNT_WIDTH = $clog2(WORD_COUNT + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_SLOT = COUNT_WIDTH'(WORD_COUNT - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   in_ready_c;
    logic                   accept;
    logic                   release_bundle;
    logic [WORD_WIDTH-1:0]  slot_q [WORD_COUNT];

    // ---------------- state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                end
                // Flush counts the word accepted in the same cycle, so a flush
                // at count 0 with an accept still releases a one-word bundle.
                if (accept && (count_q == LAST_SLOT)) begin
                    state_d = HOLD;
                end else if (bus.flush && (accept || (count_q != '0))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (release_bundle) begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        // in_ready is forced low while reset is held, independent of the clock.
        in_ready_c     = (state_q == COLLECT) && !reset;
        accept         = in_ready_c && bus.in_valid;
        release_bundle = (state_q == HOLD) && bus.out_ready;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == HOLD);   // decoded straight from the state flop
    assign bus.out_count = count_q;

    // ---------------- slot storage ----------------
    // Each slot only loads when it is the next free one; unwritten slots stay
    // zero, and a release zeroes the whole bundle for the next round.
    generate
        for (genvar gi = 0; gi < WORD_COUNT; gi++) begin : g_slot
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    slot_q[gi] <= '0;
                end else if (release_bundle) begin
                    slot_q[gi] <= '0;
                end else if (accept && (count_q == COUNT_WIDTH'(gi))) begin
                    slot_q[gi] <= bus.in_word;
                end
            end

            assign bus.out_words[gi*WORD_WIDTH +: WORD_WIDTH] = slot_q[gi];
        end
    endgenerate
endmodule

// File: tb/tb_word_slot_collector.sv
module tb_word_slot_collector;
    localparam int W  = 36;
    localparam int C  = 16;
    localparam int CW = 5;
    localparam int BW = W * C;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    word_slot_collector_if #(.WORD_WIDTH(W), .WORD_COUNT(C)) bus ();
    word_slot_collector_if #(.WORD_WIDTH(W), .WORD_COUNT(1)) bus1 ();

    word_slot_collector #(.WORD_WIDTH(W), .WORD_COUNT(C)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    word_slot_collector #(.WORD_WIDTH(W), .WORD_COUNT(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic [BW-1:0] words;
        logic [CW-1:0] cnt;
    } bundle_t;

    bundle_t exp_q[$];
    int checks = 0;
    int errors = 0;
    bit in_hold = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard monitor: compares each newly presented bundle with the
    // oldest expected one.
    always @(negedge clock) begin
        bundle_t e;
        if (bus.out_valid && !in_hold) begin
            in_hold = 1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bundle_unexpected: got words %0h expected none", bus.out_words);
            end else begin
                e = exp_q.pop_front();
                chk("bundle_words", bus.out_words, e.words);
                chk("bundle_count", BW'(bus.out_count), BW'(e.cnt));
                chk("bundle_in_ready", BW'(bus.in_ready), BW'(0));
            end
        end else if (!bus.out_valid) begin
            in_hold = 0;
        end
    end

    task automatic push_exp(input logic [BW-1:0] words, input int cnt);
        bundle_t e;
        e.words = words;
        e.cnt   = CW'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        bus.in_word  = w;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic release_and_check();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("rel_out_valid", BW'(bus.out_valid), BW'(0));
        chk("rel_count", BW'(bus.out_count), BW'(0));
        chk("rel_words", bus.out_words, BW'(0));
        chk("rel_in_ready", BW'(bus.in_ready), BW'(1));
    endtask

    initial begin
        logic [BW-1:0] ew;
        logic [BW-1:0] saved_w;
        logic [CW-1:0] saved_c;
        logic [W-1:0]  orv;

        bus.in_word = '0;  bus.in_valid = 0;  bus.flush = 0;  bus.out_ready = 0;
        bus1.in_word = '0; bus1.in_valid = 0; bus1.flush = 0; bus1.out_ready = 0;

        // Reset state
        #2;
        chk("rst_in_ready", BW'(bus.in_ready), BW'(0));
        chk("rst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("rst_count", BW'(bus.out_count), BW'(0));
        chk("rst_words", bus.out_words, BW'(0));
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", BW'(bus.in_ready), BW'(1));

        // 16 back-to-back words 1..16
        ew = '0;
        for (int k = 0; k < C; k++) ew[k*W +: W] = W'(k + 1);
        push_exp(ew, 16);
        bus.in_valid = 1'b1;
        for (int k = 0; k < C; k++) begin
            bus.in_word = W'(k + 1);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("full_out_valid", BW'(bus.out_valid), BW'(1));
        chk("full_in_ready", BW'(bus.in_ready), BW'(0));
        release_and_check();

        // 0x1, 0x2, 0x4, then flush
        ew = '0;
        ew[0*W +: W] = W'(1); ew[1*W +: W] = W'(2); ew[2*W +: W] = W'(4);
        push_exp(ew, 3);
        send(W'(1)); send(W'(2)); send(W'(4));
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_out_valid", BW'(bus.out_valid), BW'(1));
        chk("flush_count", BW'(bus.out_count), BW'(3));
        orv = '0;
        for (int k = 0; k < C; k++) orv = orv | bus.out_words[k*W +: W];
        chk("flush_or_reduce", BW'(orv), BW'(7));

        // HOLD is frozen against in_valid/flush while out_ready is low
        saved_w = bus.out_words;
        saved_c = bus.out_count;
        bus.in_word = W'('hFF); bus.in_valid = 1'b1; bus.flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_words", bus.out_words, saved_w);
            chk("hold_count", BW'(bus.out_count), BW'(saved_c));
        end
        bus.flush = 1'b0;
        // in_valid stays high through the release: no word may slip in
        release_and_check();
        bus.in_valid = 1'b0;

        // Flush at count 0 is ignored; flush with accept at count 2
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush0_out_valid", BW'(bus.out_valid), BW'(0));
        chk("flush0_count", BW'(bus.out_count), BW'(0));
        ew = '0;
        ew[0*W +: W] = W'('h10); ew[1*W +: W] = W'('h20); ew[2*W +: W] = W'('h30);
        push_exp(ew, 3);
        send(W'('h10)); send(W'('h20));
        bus.flush = 1'b1;
        send(W'('h30));
        bus.flush = 1'b0;
        chk("flushacc_out_valid", BW'(bus.out_valid), BW'(1));
        chk("flushacc_count", BW'(bus.out_count), BW'(3));
        release_and_check();

        // Reset between edges after 7 accepts
        for (int k = 0; k < 7; k++) send(W'('h100 + k));
        chk("pre_rst_count", BW'(bus.out_count), BW'(7));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", BW'(bus.out_count), BW'(0));
        chk("mid_rst_words", bus.out_words, BW'(0));
        chk("mid_rst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("mid_rst_in_ready", BW'(bus.in_ready), BW'(0));
        #1 reset = 1'b0;
        // First edge after reset release accepts a word
        ew = '0;
        ew[0*W +: W] = W'('h55);
        push_exp(ew, 1);
        send(W'('h55));
        chk("first_acc_count", BW'(bus.out_count), BW'(1));
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        release_and_check();

        // Single-slot instance
        chk("wc1_in_ready", BW'(bus1.in_ready), BW'(1));
        bus1.in_word = W'('hABC);
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("wc1_out_valid", BW'(bus1.out_valid), BW'(1));
        chk("wc1_words", BW'(bus1.out_words), BW'('hABC));
        chk("wc1_count", BW'(bus1.out_count), BW'(1));

        tick();
        tick();
        chk("scoreboard_drained", BW'(exp_q.size()), BW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
